// File: rtl/socetlib_multi_counter.sv
// socetlib_multi_counter
// Bank of NCHAN independent NBITS-wide counters. Each channel supports
// clear, parallel load, up/down counting by a shared step, an inclusive
// per-channel limit, and wrap or saturate behaviour at the bounds.
// Terminal-count events are reported on tc_flag as one-cycle pulses by
// default; define MULTI_COUNTER_STICKY_EN to make them sticky flags that
// are cleared by flag_ack, clear or RST.
module socetlib_multi_counter #(
  parameter int NBITS = 32,
  parameter int NCHAN = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCHAN-1:0]       clear,
  input  logic [NCHAN-1:0]       load,
  input  logic [NCHAN*NBITS-1:0] load_val,
  input  logic [NCHAN-1:0]       count_enable,
  input  logic [NCHAN-1:0]       down,
  input  logic [NCHAN-1:0]       saturate,
  input  logic [NBITS-1:0]       step,
  input  logic [NCHAN*NBITS-1:0] limit_val,
  input  logic [NCHAN-1:0]       flag_ack,
  output logic [NCHAN*NBITS-1:0] count_out,
  output logic [NCHAN-1:0]       at_limit,
  output logic [NCHAN-1:0]       at_zero,
  output logic [NCHAN-1:0]       tc_flag,
  output logic                   any_tc
);

`ifndef MULTI_COUNTER_STICKY_EN
  // Acknowledge has no meaning when events are plain pulses.
  logic unused_flag_ack;
  assign unused_flag_ack = ^flag_ack;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic [NBITS-1:0] cnt_q;
      logic [NBITS-1:0] cnt_d;
      logic             flag_q;
      logic             flag_d;
      logic             tc_event;
      logic [NBITS-1:0] lim;
      logic [NBITS-1:0] lval;
      logic [NBITS:0]   sum;

      assign lim  = limit_val[gi*NBITS +: NBITS];
      assign lval = load_val[gi*NBITS +: NBITS];
      // One extra bit so an up-count past the top of the range is still
      // seen as exceeding the limit rather than silently wrapping.
      assign sum  = {1'b0, cnt_q} + {1'b0, step};

      // Next count and terminal event: clear > load > count > hold.
      always_comb begin
        cnt_d    = cnt_q;
        tc_event = 1'b0;
        if (clear[gi]) begin
          cnt_d = '0;
        end else if (load[gi]) begin
          cnt_d = lval;
        end else if (count_enable[gi]) begin
          if (!down[gi]) begin
            if (sum <= {1'b0, lim}) begin
              cnt_d    = sum[NBITS-1:0];
              tc_event = (sum[NBITS-1:0] == lim);
            end else begin
              // Overshoot: either wrap to zero or pin at the limit; both
              // count as a terminal event, including repeated pinning.
              cnt_d    = saturate[gi] ? lim : '0;
              tc_event = 1'b1;
            end
          end else begin
            if (cnt_q >= step) begin
              cnt_d    = cnt_q - step;
              tc_event = (cnt_q == step);
            end else begin
              cnt_d    = saturate[gi] ? '0 : lim;
              tc_event = 1'b1;
            end
          end
        end
      end

      // Event flag next state: pulse, or sticky with set winning over ack.
      always_comb begin
        flag_d = tc_event;
`ifdef MULTI_COUNTER_STICKY_EN
        if (clear[gi]) begin
          flag_d = 1'b0;
        end else begin
          flag_d = tc_event | (flag_q & ~flag_ack[gi]);
        end
`endif
      end

      // Count and flag registers with synchronous reset.
      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_q  <= '0;
          flag_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          flag_q <= flag_d;
        end
      end

      assign count_out[gi*NBITS +: NBITS] = cnt_q;
      assign tc_flag[gi]  = flag_q;
      assign at_limit[gi] = (cnt_q == lim);
      assign at_zero[gi]  = (cnt_q == '0);
    end
  endgenerate

  assign any_tc = |tc_flag;

endmodule

// File: tb/tb_socetlib_multi_counter.sv
// Scoreboard bench for socetlib_multi_counter (NBITS=8, NCHAN=4).
// Stimulus drives inputs on the falling edge and queues the values
// expected after the next rising edge; the monitor drains the queue just
// after each rising edge and compares.
module tb_socetlib_multi_counter;
  localparam int NB = 8;
  localparam int NC = 4;
`ifdef MULTI_COUNTER_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] clear, load, en, down, sat, flag_ack;
  logic [NB-1:0] step;
  logic [NB-1:0] lv  [NC];
  logic [NB-1:0] lim [NC];
  logic [NC*NB-1:0] load_val_w, limit_w, count_out;
  logic [NC-1:0] at_limit, at_zero, tc_flag;
  logic          any_tc;

  always #5 clk = ~clk;

  always_comb begin
    load_val_w = '0;
    limit_w    = '0;
    for (int i = 0; i < NC; i++) begin
      load_val_w[i*NB +: NB] = lv[i];
      limit_w[i*NB +: NB]    = lim[i];
    end
  end

  socetlib_multi_counter #(.NBITS(NB), .NCHAN(NC)) dut (
    .CLK(clk), .RST(rst), .clear(clear), .load(load), .load_val(load_val_w),
    .count_enable(en), .down(down), .saturate(sat), .step(step),
    .limit_val(limit_w), .flag_ack(flag_ack), .count_out(count_out),
    .at_limit(at_limit), .at_zero(at_zero), .tc_flag(tc_flag), .any_tc(any_tc)
  );

  typedef struct {
    string         name;
    int            ch;
    logic [NB-1:0] cnt;
    logic          tc;
    logic          lim_hit;
    logic          zero;
    logic          any;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  task automatic expect_ch(input string nm, input int ch, input logic [NB-1:0] c,
                           input logic t, input logic a);
    exp_t e;
    e.name = nm; e.ch = ch; e.cnt = c; e.tc = t; e.any = a;
    e.lim_hit = (c == lim[ch]);
    e.zero    = (c == '0);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input string field, input int ch,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s ch%0d: got %0h expected %0h", nm, field, ch, act, want);
    end
  endtask

  // Monitor: drain every expectation queued for the edge just taken.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn %s ch%0d count=%0h tc=%b at_limit=%b at_zero=%b any_tc=%b",
                 e.name, e.ch, count_out[e.ch*NB +: NB], tc_flag[e.ch],
                 at_limit[e.ch], at_zero[e.ch], any_tc);
        chk(e.name, "count", e.ch, 32'(count_out[e.ch*NB +: NB]), 32'(e.cnt));
        chk(e.name, "tc", e.ch, 32'(tc_flag[e.ch]), 32'(e.tc));
        chk(e.name, "at_limit", e.ch, 32'(at_limit[e.ch]), 32'(e.lim_hit));
        chk(e.name, "at_zero", e.ch, 32'(at_zero[e.ch]), 32'(e.zero));
        chk(e.name, "any_tc", e.ch, 32'(any_tc), 32'(e.any));
      end
    end
    chk("end", "queue_left", 0, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stimulus with hand-computed expectations.
  initial begin
    rst = 1'b1; clear = '0; load = '0; en = '0; down = '0; sat = '0;
    step = '0;
    // Acking every cycle makes sticky flags behave like pulses for the
    // early tests; the pulse build ignores it.
    flag_ack = '1;
    lim[0] = 8'd0; lim[1] = 8'd20; lim[2] = 8'd50; lim[3] = 8'hFF;
    for (int i = 0; i < NC; i++) lv[i] = '0;
    tick();

    // Reset values; at_limit follows limit==0 on channel 0.
    for (int i = 0; i < NC; i++) expect_ch("reset", i, 8'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Wrap up: limit 9, step 1, ten enables.
    lim[0] = 8'd9; step = 8'd1; en = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      expect_ch("wrap_up", 0, (k == 10) ? 8'd0 : 8'(k), (k >= 9), (k >= 9));
      tick();
    end
    en = '0;

    // Saturate up: limit 20, step 7.
    step = 8'd7; sat[1] = 1'b1; en = 4'b0010;
    expect_ch("sat_up", 1, 8'd7,  1'b0, 1'b0); tick();
    expect_ch("sat_up", 1, 8'd14, 1'b0, 1'b0); tick();
    expect_ch("sat_up", 1, 8'd20, 1'b1, 1'b1); tick();
    expect_ch("sat_up", 1, 8'd20, 1'b1, 1'b1); tick();
    en = '0;
    expect_ch("sat_hold", 1, 8'd20, 1'b0, 1'b0); tick();

    // Down wrap: load 5, step 2, limit 50.
    load = 4'b0100; lv[2] = 8'd5;
    expect_ch("dn_load", 2, 8'd5, 1'b0, 1'b0); tick();
    load = '0; down[2] = 1'b1; step = 8'd2; en = 4'b0100;
    expect_ch("dn_wrap", 2, 8'd3,  1'b0, 1'b0); tick();
    expect_ch("dn_wrap", 2, 8'd1,  1'b0, 1'b0); tick();
    expect_ch("dn_wrap", 2, 8'd50, 1'b1, 1'b1); tick();
    expect_ch("dn_wrap", 2, 8'd48, 1'b0, 1'b0); tick();
    en = '0;

    // Priority on channel 3: clear beats load beats enable.
    load = 4'b1000; lv[3] = 8'h10;
    expect_ch("prio_pre", 3, 8'h10, 1'b0, 1'b0); tick();
    clear = 4'b1000; load = 4'b1000; lv[3] = 8'h33; en = 4'b1000; step = 8'd1;
    expect_ch("prio_clr", 3, 8'h00, 1'b0, 1'b0); tick();
    clear = '0;
    expect_ch("prio_load", 3, 8'h33, 1'b0, 1'b0); tick();
    load = '0;
    expect_ch("prio_cnt", 3, 8'h34, 1'b0, 1'b0); tick();
    en = '0;

    // Step 0: down at zero and saturated up at limit both report tc.
    step = 8'd0; down[0] = 1'b1; en = 4'b0011;
    expect_ch("step0_dn", 0, 8'd0,  1'b1, 1'b1);
    expect_ch("step0_up", 1, 8'd20, 1'b1, 1'b1);
    tick();
    en = '0; down[0] = 1'b0;

    // Load above limit is held, then the next count wraps.
    load = 4'b0001; lv[0] = 8'd15;
    expect_ch("over_load", 0, 8'd15, 1'b0, 1'b0); tick();
    load = '0; en = 4'b0001; step = 8'd1;
    expect_ch("over_wrap", 0, 8'd0, 1'b1, 1'b1); tick();
    en = '0;

    // All channels concurrently: ch0 up wrap lim 9, ch1 up sat lim 20,
    // ch2 down wrap lim 50, ch3 up sat lim 0x36; step 3.
    lim[3] = 8'h36; sat[3] = 1'b1; step = 8'd3; en = 4'b1111;
    expect_ch("multi", 0, 8'd3, 1'b0, 1'b1);  expect_ch("multi", 1, 8'd20, 1'b1, 1'b1);
    expect_ch("multi", 2, 8'd45, 1'b0, 1'b1); expect_ch("multi", 3, 8'h36, 1'b1, 1'b1);
    tick();
    expect_ch("multi", 0, 8'd6, 1'b0, 1'b1);  expect_ch("multi", 1, 8'd20, 1'b1, 1'b1);
    expect_ch("multi", 2, 8'd42, 1'b0, 1'b1); expect_ch("multi", 3, 8'h36, 1'b1, 1'b1);
    tick();
    expect_ch("multi", 0, 8'd9, 1'b1, 1'b1);  expect_ch("multi", 1, 8'd20, 1'b1, 1'b1);
    expect_ch("multi", 2, 8'd39, 1'b0, 1'b1); expect_ch("multi", 3, 8'h36, 1'b1, 1'b1);
    tick();
    expect_ch("multi", 0, 8'd0, 1'b1, 1'b1);  expect_ch("multi", 1, 8'd20, 1'b1, 1'b1);
    expect_ch("multi", 2, 8'd36, 1'b0, 1'b1); expect_ch("multi", 3, 8'h36, 1'b1, 1'b1);
    tick();

    // Reset mid-count, enables still active.
    rst = 1'b1;
    for (int i = 0; i < NC; i++) expect_ch("rst_mid", i, 8'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; en = '0; down = '0; sat = '0; flag_ack = '0;

    // Event flag behaviour on ch0 (limit 2, step 1, wrap up).
    lim[0] = 8'd2; step = 8'd1; en = 4'b0001;
    expect_ch("flag", 0, 8'd1, 1'b0, 1'b0); tick();
    expect_ch("flag", 0, 8'd2, 1'b1, 1'b1); tick();
    en = '0;
    for (int k = 0; k < 5; k++) begin
      expect_ch("flag_idle", 0, 8'd2, STICKY, STICKY); tick();
    end
    flag_ack = 4'b0001;
    expect_ch("flag_ack", 0, 8'd2, 1'b0, 1'b0); tick();
    en = 4'b0001;
    expect_ch("flag_ack_tc", 0, 8'd0, 1'b1, 1'b1); tick();
    en = '0; flag_ack = '0;
    expect_ch("flag_idle2", 0, 8'd0, STICKY, STICKY); tick();
    clear = 4'b0001; en = 4'b0001;
    expect_ch("flag_clear", 0, 8'd0, 1'b0, 1'b0); tick();
    clear = '0; en = '0;
    tick();
    done = 1;
  end

  // Backstop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/socetlib_multi_counter.md
# socetlib_multi_counter

Bank of NCHAN independent, parametrised-width counters with per-channel clear, parallel load, up/down direction, programmable step, per-channel limit, and wrap or saturate mode. It is the general-purpose successor to the single-channel overflow counter, serving tile-loop indices, stall timers and event counters in the tensor-core controller. Each channel reports terminal-count events. Events can be pulses or sticky flags, selected at compile time.

## Interface
Parameters:
- NBITS, 32, width of each counter, step and limit
- NCHAN, 4, number of independent channels (≥1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- clear  in  NCHAN  per-channel synchronous clear
- load  in  NCHAN  per-channel parallel load
- load_val  in  NCHAN*NBITS  load values; channel i at [i*NBITS +: NBITS]
- count_enable  in  NCHAN  per-channel count strobe
- down  in  NCHAN  1 = count down, 0 = count up
- saturate  in  NCHAN  1 = saturate at bound, 0 = wrap
- step  in  NBITS  increment/decrement amount, shared by all channels
- limit_val  in  NCHAN*NBITS  per-channel upper bound (inclusive)
- flag_ack  in  NCHAN  clears sticky tc_flag; ignored without the macro
- count_out  out  NCHAN*NBITS  registered counts
- at_limit  out  NCHAN  count_out[i] == limit_val[i]
- at_zero  out  NCHAN  count_out[i] == 0
- tc_flag  out  NCHAN  terminal-count event, registered
- any_tc  out  1  OR of tc_flag

## Operation
- Per-channel priority, evaluated each cycle: clear > load > count_enable > hold.
- Clear sets count ← 0 and does not raise tc.
- Load sets count ← load_val[i], with no bound check. A loaded value above the limit is held as-is until the next count. Load does not raise tc.
- Count up: compute sum = count + step at NBITS+1 bits.
  - sum ≤ limit: count ← sum.
  - sum > limit, wrap mode: count ← 0.
  - sum > limit, saturate mode: count ← limit.
- Count down:
  - count ≥ step: count ← count − step.
  - count < step, wrap mode: count ← limit.
  - count < step, saturate mode: count ← 0.
- A terminal event (tc) occurs on a counting cycle when any of these holds:
  - the result hits the bound: up result == limit, or down result == 0;
  - the count wraps;
  - the count saturates. This includes the case where the count was already at the bound, so a saturated channel repeats tc on every enabled cycle.
- step = 0 with enable active: count is unchanged, and tc follows the rules above (tc if the count sits at the bound).
- Channels are fully independent; there is no cross-channel interaction.
- at_limit and at_zero are combinational compares of the count register against limit_val and 0.

## Timing
- All state updates occur on the rising edge of CLK.
- Reset values while RST=1 at an edge: count_out = 0, tc_flag = 0, any_tc = 0. at_zero = all 1s. at_limit reflects limit_val == 0.
- RST overrides all other inputs, including mid-count.
- count_out updates one cycle after the cycle in which clear/load/enable was sampled.
- tc_flag rises in the same edge as the count update that caused it, giving 1-cycle latency from the enable strobe.
- any_tc is combinational from the tc_flag registers (same cycle).
- Changes on limit_val take effect at the next evaluated count. at_limit responds combinationally.

## Configuration
- Macro: MULTI_COUNTER_STICKY_EN.
- Macro defined:
  - tc_flag[i] is sticky once set.
  - It clears only on flag_ack[i], clear[i] or RST.
  - If a new tc and flag_ack occur in the same cycle, the flag stays 1 (set wins).
  - clear[i] together with enable is treated as clear, so the flag goes to 0.
- Macro undefined:
  - tc_flag[i] is a one-cycle pulse per tc event.
  - flag_ack is ignored.
  - Continuous saturation produces back-to-back pulses.

## Test plan
- Wrap up, NBITS=8: limit=9, step=1, enable 10 cycles from reset → count sequence 1..9 then 0. tc pulses on the cycle count becomes 9 and again on the wrap to 0.
- Saturate up: limit=20, step=7, saturate=1, 4 enables → counts 7, 14, 20, 20. tc on the 3rd and 4th updates; at_limit=1 after the 3rd.
- Down wrap: load 5, down=1, step=2, 4 enables → counts 3, 1, limit, limit−2. tc on the wrap cycle.
- Priority: clear, load=0x33 and enable all asserted in the same cycle → count 0 and no tc. Next cycle load+enable asserted → count 0x33.
- Sticky flag (macro on): trigger tc, hold 5 idle cycles → tc_flag stays 1 and any_tc = 1. Assert flag_ack → tc_flag = 0 next cycle. flag_ack coinciding with a new tc → tc_flag stays 1.
- Channel independence and reset: NCHAN=4, different limits/modes running concurrently → each matches its own model. RST asserted mid-count → all outputs return to reset values at the next edge.
